fetch_sequencer: RTL and testbench

Sequences instruction fetch for the Eka core. It sits between `pc_control` and the instruction-memory port. It issues one word-aligned request per PC value and holds the returned instruction for the core. It drives the `stall` input of `pc_control` so the PC advances only when the core consumes an instruction. It also handles flushes, including discarding a response that is already in flight.

---
 rtl/eka_fetch_pkg.sv | 8 +
 rtl/fetch_perf_counter.sv | 23 ++
 rtl/fetch_sequencer.sv | 139 +++++++++++++
 tb/tb_fetch_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eka_fetch_pkg.sv
// rtl/eka_fetch_pkg.sv - shared state encoding and constants for the Eka fetch sequencer
package eka_fetch_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_perf_counter.sv
// rtl/fetch_perf_counter.sv - 32-bit wrapping enable counter, built only when FETCH_PERF_EN is defined
`ifdef FETCH_PERF_EN
module fetch_perf_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule
`endif

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - one-outstanding instruction fetch between pc_control and imem; FETCH_PERF_EN adds perf counters
module fetch_sequencer
  import eka_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-3:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-3:0] pc,
  input  logic                  flush,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr,
  output logic                  pc_stall
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetches,
  output logic [31:0]           perf_wait_cycles
`endif
);

  fetch_state_t          r_state;
  fetch_state_t          w_next;
  logic [ADDR_WIDTH-3:0] r_pc_q;
  logic [ADDR_WIDTH-3:0] w_pc_q;
  logic                  r_pc_fresh;
  logic                  r_discard;
  logic [31:0]           r_instr;
  logic                  w_set_discard;
  logic                  w_clr_discard;
  logic                  w_load_instr;

  // pc_control advances on the edge that leaves HOLD, so the new PC is taken
  // in the first REQ cycle; pc is stalled for the rest of REQ.
  assign w_pc_q = (r_state == REQ && r_pc_fresh) ? pc : r_pc_q;

  always_comb begin
    w_next        = r_state;
    w_set_discard = 1'b0;
    w_clr_discard = 1'b0;
    w_load_instr  = 1'b0;
    case (r_state)
      IDLE: w_next = REQ;
      REQ: begin
        if (flush) begin
          w_next = IDLE;
        end else if (imem_req_ready) begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          if (imem_rsp_valid) begin
            w_next        = IDLE;
            w_clr_discard = 1'b1;
          end else begin
            w_set_discard = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (r_discard) begin
            w_next        = REQ;
            w_clr_discard = 1'b1;
          end else begin
            w_next       = HOLD;
            w_load_instr = 1'b1;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          w_next = IDLE;
        end else if (instr_ready) begin
          w_next = REQ;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc_q     <= RESET_ADDR;
      r_pc_fresh <= 1'b0;
      r_discard  <= 1'b0;
      r_instr    <= '0;
    end else begin
      r_state    <= w_next;
      r_pc_fresh <= (w_next == REQ) && (r_state != REQ);
      if (r_state == REQ) begin
        r_pc_q <= w_pc_q;
      end
      if (w_set_discard) begin
        r_discard <= 1'b1;
      end else if (w_clr_discard) begin
        r_discard <= 1'b0;
      end
      if (w_load_instr) begin
        r_instr <= imem_rsp_data;
      end
    end
  end

  // A flushed request is withdrawn at once so memory never accepts an orphan.
  assign imem_req_valid = (r_state == REQ) && !flush;
  assign imem_req_addr  = {w_pc_q, 2'b00};
  assign instr_valid    = (r_state == HOLD);
  assign instr          = r_instr;
  assign pc_stall       = !((r_state == HOLD) && instr_ready && !flush);

`ifdef FETCH_PERF_EN
  logic w_fetch_en;
  logic w_wait_en;

  assign w_fetch_en = instr_valid && instr_ready;
  assign w_wait_en  = (r_state == REQ) || (r_state == WAIT);

  fetch_perf_counter u_perf_fetches (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_fetch_en),
    .o_count (perf_fetches)
  );

  fetch_perf_counter u_perf_wait (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_wait_en),
    .o_count (perf_wait_cycles)
  );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer with pc_control and memory models
module tb_fetch_sequencer;
  import eka_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, instr_ready, imem_req_ready, imem_rsp_valid;
  logic        imem_req_valid, instr_valid, pc_stall;
  logic [29:0] pc;
  logic [31:0] imem_req_addr, imem_rsp_data, instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetches, perf_wait_cycles;
`endif

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_WIDTH(32), .RESET_ADDR(30'h0)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .pc_stall       (pc_stall)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetches     (perf_fetches),
    .perf_wait_cycles (perf_wait_cycles)
`endif
  );

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] word;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_q[$];
  logic [31:0] prog[256];

  int          k_rdy = 100, k_irdy = 100, k_flush = 0, k_dmin = 1, k_dmax = 1;
  bit          k_reset = 1'b1, k_flush_once = 1'b0, k_force_dead = 1'b0;
  logic [29:0] k_target = '0;

  logic [29:0] m_pc;
  bit          m_busy;
  int          m_cnt;
  logic [29:0] m_addr;

  bit          s_reset, s_flush, s_acc, s_cons, s_rsp, s_ivalid, s_req_valid, s_stall;
  logic [31:0] s_addr, s_instr;
  logic [29:0] s_target, s_cons_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [29:0] p);
    exp_t e;
    e.pc   = p;
    e.word = prog[p[7:0]];
    return e;
  endfunction

  task automatic model_reset();
    m_pc   = '0;
    m_busy = 1'b0;
    m_cnt  = 0;
    exp_q.delete();
    exp_q.push_back(mk(30'd0));
  endtask

  // One cycle: drive inputs at negedge, sample at negedge+1, advance the
  // pc_control and memory models after the rising edge.
  task automatic step();
    @(negedge clk);
    reset          = k_reset;
    flush          = k_flush_once || ($urandom_range(0, 99) < k_flush);
    s_target       = k_flush_once ? k_target : 30'($urandom_range(0, 200));
    k_flush_once   = 1'b0;
    imem_req_ready = ($urandom_range(0, 99) < k_rdy);
    instr_ready    = ($urandom_range(0, 99) < k_irdy);
    imem_rsp_valid = m_busy && (m_cnt == 1);
    imem_rsp_data  = INSTR_NOP;
    if (imem_rsp_valid) begin
      imem_rsp_data = k_force_dead ? 32'hDEADBEEF : prog[m_addr[7:0]];
      k_force_dead  = 1'b0;
    end
    pc = m_pc;
    #1;
    s_reset     = reset;
    s_flush     = flush;
    s_req_valid = imem_req_valid;
    s_addr      = imem_req_addr;
    s_acc       = imem_req_valid && imem_req_ready;
    s_rsp       = imem_rsp_valid;
    s_ivalid    = instr_valid;
    s_instr     = instr;
    s_stall     = pc_stall;
    s_cons      = instr_valid && instr_ready && !flush;
    s_cons_pc   = (exp_q.size() > 0) ? exp_q[0].pc : '0;
    @(posedge clk);
    if (s_reset) begin
      model_reset();
    end else begin
      if (m_busy) begin
        if (s_rsp) m_busy = 1'b0;
        else m_cnt--;
      end
      if (s_acc) begin
        m_busy = 1'b1;
        m_cnt  = $urandom_range(k_dmin, k_dmax);
        m_addr = s_addr[31:2];
      end
      if (s_flush) begin
        m_pc = s_target;
        exp_q.delete();
        exp_q.push_back(mk(s_target));
      end else begin
        if (!s_stall) m_pc = m_pc + 30'd1;
        if (s_cons) exp_q.push_back(mk(s_cons_pc + 30'd1));
      end
    end
  endtask

  initial begin : monitor
    bit          p_reset = 1'b0, p_req = 1'b0, p_rdy = 1'b0, p_flush = 1'b0, p_iv = 1'b0, p_irdy = 1'b0;
    logic [31:0] p_addr = '0, p_instr = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        if (p_reset) begin
          chk("reset_req_valid", imem_req_valid, 0);
          chk("reset_instr_valid", instr_valid, 0);
          chk("reset_instr", instr, 32'h0);
          chk("reset_pc_stall", pc_stall, 1);
        end
      end else begin
        chk("pc_stall", pc_stall, !(instr_valid && instr_ready && !flush));
        chk("req_while_busy", imem_req_valid && m_busy, 0);
        if (imem_req_valid && imem_req_ready) begin
          if (exp_q.size() == 0) chk("req_q_size", 0, 1);
          else chk("req_addr", imem_req_addr, {exp_q[0].pc, 2'b00});
        end
        if (instr_valid && instr_ready && !flush) begin
          if (exp_q.size() == 0) begin
            chk("cons_q_size", 0, 1);
          end else begin
            e = exp_q.pop_front();
            chk("instr", instr, e.word);
          end
        end
        if (!p_reset && p_req && !p_rdy && !p_flush && !flush) begin
          chk("req_hold_valid", imem_req_valid, 1);
          chk("req_hold_addr", imem_req_addr, p_addr);
        end
        if (!p_reset && p_iv && !p_irdy && !p_flush) begin
          chk("instr_hold_valid", instr_valid, 1);
          chk("instr_hold_data", instr, p_instr);
        end
        if (!p_reset && p_iv && p_flush) chk("flush_drops_valid", instr_valid, 0);
      end
      p_reset = reset;
      p_req   = imem_req_valid;
      p_rdy   = imem_req_ready;
      p_flush = flush;
      p_iv    = instr_valid;
      p_irdy  = instr_ready;
      p_addr  = imem_req_addr;
      p_instr = instr;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int          cyc, first, ncons, n, rst_left, rand_cons;
    logic [31:0] a0, i0;
    logic [31:0] acc_q[$];

    for (int i = 0; i < 256; i++) prog[i] = $urandom;
    reset = 1'b1; flush = 1'b0; instr_ready = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = INSTR_NOP; pc = '0;
    model_reset();

    k_reset = 1'b1;
    repeat (3) step();

    // first fetch latency and ten back-to-back fetches from pc 0
    k_reset = 1'b0;
    cyc = 0; first = -1; ncons = 0;
    while (ncons < 10 && cyc < 100) begin
      step();
      if (s_ivalid && first < 0) first = cyc;
      if (s_acc) acc_q.push_back(s_addr);
      if (s_cons) ncons++;
      cyc++;
    end
    chk("first_valid_cycle", first, 3);
    chk("b2b_count", ncons, 10);
    chk("b2b_cycles", cyc, 31);
    for (int i = 0; i < 10; i++)
      chk("b2b_addr", (i < acc_q.size()) ? acc_q[i] : 32'hFFFF_FFFF, 32'(i * 4));

    // request held while memory is not ready
    k_rdy = 0; n = 0;
    do begin step(); n++; end while (!s_req_valid && n < 20);
    chk("stall_req_seen", s_req_valid, 1);
    a0 = s_addr;
    chk("stall_req_addr", a0, 32'd40);
    repeat (5) begin
      step();
      chk("stall_req_valid", s_req_valid, 1);
      chk("stall_req_addr_stable", s_addr, a0);
    end
    k_rdy = 100;

    // instruction held while the core is not ready
    k_irdy = 0; n = 0;
    do begin step(); n++; end while (!s_ivalid && n < 20);
    chk("hold_seen", s_ivalid, 1);
    i0 = s_instr;
    chk("hold_instr", i0, prog[10]);
    repeat (4) begin
      step();
      chk("hold_valid", s_ivalid, 1);
      chk("hold_data", s_instr, i0);
      chk("hold_stall", s_stall, 1);
    end
    chk("hold_pc", m_pc, 32'd10);
    k_irdy = 100; n = 0;
    do begin step(); n++; end while (!s_cons && n < 20);
    chk("hold_consumed", s_cons, 1);

    // flush while waiting: the in-flight response is dropped
    k_dmin = 3; k_dmax = 3; n = 0;
    do begin step(); n++; end while (!m_busy && n < 20);
    chk("wait_reached", m_busy, 1);
    k_flush_once = 1'b1; k_target = 30'd100; k_force_dead = 1'b1;
    step();
    k_dmin = 1; k_dmax = 1; n = 0;
    do begin step(); n++; end while (!s_rsp && n < 10);
    chk("discard_rsp_seen", s_rsp, 1);
    step();
    chk("discard_no_valid", s_ivalid, 0);
    chk("refetch_acc", s_acc, 1);
    chk("refetch_addr", s_addr, 32'd400);
    n = 0;
    do begin step(); n++; end while (!s_cons && n < 20);
    chk("refetch_consumed", s_cons, 1);

    // flush and instr_ready together in HOLD
    k_irdy = 0; n = 0;
    do begin step(); n++; end while (!s_ivalid && n < 20);
    chk("fh_seen", s_ivalid, 1);
    k_irdy = 100; k_flush_once = 1'b1; k_target = 30'd20;
    step();
    chk("fh_stall", s_stall, 1);
    step();
    chk("fh_valid_dropped", s_ivalid, 0);
    chk("fh_idle_no_req", s_req_valid, 0);
    n = 0;
    do begin step(); n++; end while (!s_cons && n < 20);
    chk("fh_refetch_consumed", s_cons, 1);

    // randomized traffic with flushes and occasional resets
    k_rdy = 70; k_irdy = 60; k_flush = 4; k_dmin = 1; k_dmax = 3;
    rst_left = 0; rand_cons = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = 3;
      k_reset = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      step();
      if (s_cons && !s_reset) rand_cons++;
    end
    k_reset = 1'b0; k_flush = 0; k_rdy = 100; k_irdy = 100;
    repeat (20) step();
    chk("random_progress", rand_cons > 100, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
